// File: rtl/bus_grant_ctrl_if.sv
// Bus grant interface between requesters and bus_grant_ctrl.
//
// Signals:
//   req      level request per bus source (requester -> controller)
//   req_dst  destination index per requester, slice i = [i*DSTW +: DSTW]
//   oe       one-hot-or-zero source output-enable
//   ld       one-hot-or-zero destination load-enable
//   done     one-cycle pulse, transfer of requester i completes
//   err_dst  one-cycle pulse, granted destination index >= NDST
//   busy     high while the bus is driven or turning around
//
// Modports: master = requester side, slave = controller side.
interface bus_grant_ctrl_if #(
  parameter int NREQ = 4,
  parameter int NDST = 8
);
  localparam int DSTW = $clog2(NDST);

  logic [NREQ-1:0]      req;
  logic [NREQ*DSTW-1:0] req_dst;
  logic [NREQ-1:0]      oe;
  logic [NDST-1:0]      ld;
  logic [NREQ-1:0]      done;
  logic                 err_dst;
  logic                 busy;

  modport master (
    output req, req_dst,
    input  oe, ld, done, err_dst, busy
  );

  modport slave (
    input  req, req_dst,
    output oe, ld, done, err_dst, busy
  );
endinterface

// File: rtl/bus_grant_ctrl.sv
// Sequencer and round-robin arbiter for the shared internal tri-state bus.
// Grants the bus to one requester at a time: one DRIVE cycle with exactly
// one source output-enable and at most one destination load-enable, then a
// TURN dead cycle so two tri-state drivers are never enabled together.
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous active-low reset
//   bus  bus_grant_ctrl_if.slave (req, req_dst in; oe, ld, done, err_dst,
//        busy out). All outputs are registered.
module bus_grant_ctrl #(
  parameter int NREQ = 4,
  parameter int NDST = 8
) (
  input  logic            clk,
  input  logic            rst,
  bus_grant_ctrl_if.slave bus
);

  localparam int DSTW = $clog2(NDST);
  localparam int IW   = $clog2(NREQ);

  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
  localparam logic [IW:0]   NREQ_W   = (IW + 1)'(NREQ);
  localparam logic [DSTW:0] NDST_LIM = (DSTW + 1)'(NDST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   win;
  logic [IW:0]     sum;
  logic            found;
  logic            grant;
  logic [NREQ-1:0] elig;
  logic [DSTW-1:0] dst_sel;
  logic [DSTW-1:0] dst_arr [NREQ];

  logic [NREQ-1:0] oe_d, oe_q;
  logic [NDST-1:0] ld_d, ld_q;
  logic [NREQ-1:0] done_d, done_q;
  logic            err_d, err_q;
  logic            busy_d, busy_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_dst
    assign dst_arr[g] = bus.req_dst[g*DSTW +: DSTW];
  end

  // Arbitration and next-state / next-output decode
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    elig    = '0;
    sum     = '0;
    found   = 1'b0;
    win     = '0;
    grant   = 1'b0;
    dst_sel = '0;
    oe_d    = '0;
    ld_d    = '0;
    done_d  = '0;
    err_d   = 1'b0;
    busy_d  = 1'b0;

    // The requester served in the previous DRIVE is masked in TURN so a
    // requester still holding req for one cycle after done is not re-served.
    case (state_q)
      IDLE:    elig = bus.req;
      TURN: begin
        elig         = bus.req;
        elig[last_q] = 1'b0;
      end
      default: elig = '0;
    endcase

    // Scan ptr, ptr+1, ... modulo NREQ for the first eligible request.
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IW + 1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && elig[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
    grant   = found;
    dst_sel = dst_arr[win];

    case (state_q)
      IDLE:    state_d = grant ? DRIVE : IDLE;
      DRIVE:   state_d = TURN;
      TURN:    state_d = grant ? DRIVE : IDLE;
      default: state_d = IDLE;
    endcase

    if (grant) begin
      ptr_d        = (win == LAST_IDX) ? '0 : win + IW'(1);
      last_d       = win;
      oe_d[win]    = 1'b1;
      done_d[win]  = 1'b1;
      // Out-of-range destinations drop the transfer but still complete it.
      if ({1'b0, dst_sel} < NDST_LIM) ld_d[dst_sel] = 1'b1;
      else                            err_d         = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      oe_q    <= '0;
      ld_q    <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      oe_q    <= oe_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.oe      = oe_q;
  assign bus.ld      = ld_q;
  assign bus.done    = done_q;
  assign bus.err_dst = err_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Self-checking bench for bus_grant_ctrl (NREQ=4, NDST=6 so that indices 6
// and 7 exercise the invalid-destination path).
// A history-based reference model predicts every cycle's outputs into a
// queue; a negedge monitor pops and compares, and also checks the bus
// invariants. Directed sequences add hand-derived constant checks, then a
// randomized protocol-compliant requester population runs for 10k cycles.
module tb_bus_grant_ctrl;
  localparam int NREQ = 4;
  localparam int NDST = 6;
  localparam int DSTW = $clog2(NDST);

  typedef struct packed {
    logic [NREQ-1:0] oe;
    logic [NDST-1:0] ld;
    logic [NREQ-1:0] done;
    logic            err;
    logic            busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_grant_ctrl_if #(.NREQ(NREQ), .NDST(NDST)) bus ();
  bus_grant_ctrl #(.NREQ(NREQ), .NDST(NDST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  exp_t q[$];
  logic [NREQ-1:0] done_obs = '0;
  logic [NREQ-1:0] prev_oe  = '0;

  // model state: history of grants rather than an FSM
  int m_ptr      = 0;
  int m_cyc      = 0;
  int m_last_cyc = -100;
  int m_last_own = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req_v, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    logic [NREQ-1:0] elig;
    int w, d, c;
    bit turn;
    e = '0;
    w = -1;
    m_cyc++;
    if (!rst) begin
      m_ptr = 0;
      m_last_cyc = -100;
      q.push_back(e);
      return;
    end
    // a grant on the previous edge means this cycle is the dead cycle
    turn = (m_last_cyc == m_cyc - 1);
    if (!turn) begin
      elig = bus.req;
      if (m_last_cyc == m_cyc - 2) elig[m_last_own] = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (w < 0 && elig[c]) w = c;
      end
      if (w >= 0) begin
        d = int'(bus.req_dst[w*DSTW +: DSTW]);
        e.oe[w]   = 1'b1;
        e.done[w] = 1'b1;
        if (d < NDST) e.ld[d] = 1'b1;
        else          e.err   = 1'b1;
        m_ptr      = (w + 1) % NREQ;
        m_last_cyc = m_cyc;
        m_last_own = w;
      end
    end
    e.busy = turn || (w >= 0);
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  // monitor: scoreboard compare plus invariants
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      done_obs = bus.done;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_oe",   32'(bus.oe),      32'(e.oe));
        chk("sb_ld",   32'(bus.ld),      32'(e.ld));
        chk("sb_done", 32'(bus.done),    32'(e.done));
        chk("sb_err",  32'(bus.err_dst), 32'(e.err));
        chk("sb_busy", 32'(bus.busy),    32'(e.busy));
      end
      chk("oe_onehot0", 32'($onehot0(bus.oe)), 32'd1);
      chk("ld_onehot0", 32'($onehot0(bus.ld)), 32'd1);
      chk("oe_back_to_back", 32'((prev_oe != '0) && (bus.oe != '0)), 32'd0);
      prev_oe = bus.oe;
    end
  end

  logic [NREQ-1:0] pend;
  int waitc [NREQ];
  int served;

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.req_dst = '0;
    pend = '0;
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    #2 rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_oe",   32'(bus.oe),      32'd0);
    chk("rst_ld",   32'(bus.ld),      32'd0);
    chk("rst_done", 32'(bus.done),    32'd0);
    chk("rst_err",  32'(bus.err_dst), 32'd0);
    chk("rst_busy", 32'(bus.busy),    32'd0);

    // reset in the middle of a DRIVE cycle
    tick();
    rst = 1'b1;
    bus.req = 4'b0010;
    tick();
    @(negedge clk);
    chk("pre_rst_oe", 32'(bus.oe), 32'h2);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_oe",   32'(bus.oe),   32'd0);
    chk("async_rst_ld",   32'(bus.ld),   32'd0);
    chk("async_rst_done", 32'(bus.done), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    q.delete();
    tick();
    tick();
    bus.req = 4'b1111;
    bus.req_dst = '0;
    bus.req_dst[0*DSTW +: DSTW] = 3'd1;
    bus.req_dst[1*DSTW +: DSTW] = 3'd2;
    bus.req_dst[2*DSTW +: DSTW] = 3'd3;
    bus.req_dst[3*DSTW +: DSTW] = 3'd4;
    rst = 1'b1;

    // round robin with all requests held
    for (int c = 0; c < 12; c++) begin
      tick();
      @(negedge clk);
      if (c % 2 == 0) begin
        chk("rr_oe", 32'(bus.oe), 32'(1) << ((c / 2) % 4));
        chk("rr_ld", 32'(bus.ld), 32'(1) << (((c / 2) % 4) + 1));
      end else begin
        chk("rr_oe_turn", 32'(bus.oe), 32'd0);
      end
    end
    bus.req = '0;
    repeat (3) tick();

    // single transfer
    bus.req = 4'b0100;
    bus.req_dst = '0;
    bus.req_dst[2*DSTW +: DSTW] = 3'd5;
    tick();
    @(negedge clk);
    chk("single_oe",   32'(bus.oe),   32'h4);
    chk("single_ld",   32'(bus.ld),   32'h20);
    chk("single_done", 32'(bus.done), 32'h4);
    chk("single_busy", 32'(bus.busy), 32'd1);
    bus.req = '0;
    tick();
    @(negedge clk);
    chk("turn_oe",   32'(bus.oe),   32'd0);
    chk("turn_ld",   32'(bus.ld),   32'd0);
    chk("turn_busy", 32'(bus.busy), 32'd1);
    tick();
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // one requester holding req continuously
    bus.req = 4'b0001;
    served = 0;
    repeat (9) begin
      tick();
      @(negedge clk);
      if (bus.oe[0]) served++;
    end
    chk("hold_served_min3", 32'(served >= 3), 32'd1);
    bus.req = '0;
    repeat (3) tick();

    // invalid destination
    bus.req = 4'b0010;
    bus.req_dst = '0;
    bus.req_dst[1*DSTW +: DSTW] = 3'd7;
    tick();
    @(negedge clk);
    chk("inv_oe",   32'(bus.oe),      32'h2);
    chk("inv_ld",   32'(bus.ld),      32'd0);
    chk("inv_err",  32'(bus.err_dst), 32'd1);
    chk("inv_done", 32'(bus.done),    32'h2);
    bus.req = '0;
    repeat (3) tick();

    // random protocol-compliant requesters
    for (int n = 0; n < 10000; n++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          if (done_obs[i]) begin
            chk("latency", 32'(waitc[i] <= 2 * NREQ), 32'd1);
            pend[i] = 1'b0;
            bus.req[i] = 1'b0;
          end else begin
            waitc[i]++;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          waitc[i] = 0;
          bus.req[i] = 1'b1;
          bus.req_dst[i*DSTW +: DSTW] = DSTW'($urandom_range(0, 7));
        end
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (pend[i]) chk("stuck", 32'(waitc[i] <= 2 * NREQ), 32'd1);
    bus.req = '0;
    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
